gemm_tile_scheduler: RTL and testbench
======================================

# gemm_tile_scheduler

Sequences one large GEMM job (D = A·B + C, arbitrary M×K×N up to the DIM_WIDTH limit) into a stream of 16×16 tile commands for the control unit's 64-bit host command port. It generates per-tile SRAM base addresses and edge-tile lengths, and orders the K-reduction so that partial sums are chained through the D buffer. It counts outstanding tiles via done_irq and signals job completion. It sits between the host job register and control_unit.

## Interface
- ADDR_WIDTH, 10, SRAM row-address width; 4*ADDR_WIDTH+24 must be ≤ 64.
- SYSTOLIC_ARRAY_WIDTH, 16, tile edge W.
- DIM_WIDTH, 10, width of job dimension fields, in elements.
- MAX_OUTSTANDING, 4, maximum tiles issued but not yet completed.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  high only in IDLE.
- job_m, job_k, job_n  in  DIM_WIDTH each  matrix dimensions in elements.
- job_base_a, job_base_b, job_base_c, job_base_d  in  ADDR_WIDTH each  SRAM base rows.
- cmd_valid  out  1  tile command valid.
- cmd_ready  in  1  control_unit FIFO not full.
- cmd_data  out  64  packed command: len_m[7:0], len_k[15:8], len_n[23:16], addr_a, addr_b, addr_c, addr_d at ascending ADDR_WIDTH slices from bit 24; unused upper bits 0.
- done_irq  in  1  one-cycle pulse per completed tile.
- busy  out  1  state ≠ IDLE.
- job_done  out  1  one-cycle completion pulse.
- job_err  out  1  one-cycle pulse on a rejected job.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight tile count.

## Operation
- Tile counts: MT = ceil(job_m/W), KT = ceil(job_k/W), NT = ceil(job_n/W). Latch all job fields on accept.
- Iteration order: mi (outer), ni, ki (inner). Each index starts at 0.
- Addresses, all modulo 2^ADDR_WIDTH:
  - addr_a = base_a + (mi·KT+ki)·W
  - addr_b = base_b + (ni·KT+ki)·W
  - addr_d = base_d + (mi·NT+ni)·W
  - addr_c = base_c + (mi·NT+ni)·W when ki = 0; otherwise addr_c = addr_d, which chains the partial sum.
- Implement the addresses with running adders. Multipliers are not allowed.
- Lengths: len_x = min(W, dim_x − idx·W), zero-extended to 8 bits.
- State machine:
  - IDLE: job_ready = 1. On job_valid: if any dimension is 0, pulse job_err and stay in IDLE. Otherwise go to ISSUE.
  - ISSUE: present the tile. Go to STALL when an issue condition fails.
  - STALL: cmd_valid = 0. Return to ISSUE when both issue conditions hold.
  - DRAIN: wait for outstanding = 0.
  - DONE: pulse job_done for one cycle, then go to IDLE.
- Issue conditions, both required:
  - outstanding < MAX_OUTSTANDING.
  - if ki > 0, outstanding = 0. This is the RAW hazard on the D partial sum.
- Transfer occurs when cmd_valid && cmd_ready.
  - On a transfer of the last tile (mi=MT−1, ni=NT−1, ki=KT−1), go to DRAIN.
  - On any other transfer, advance the indices and stay in ISSUE/STALL as the issue conditions dictate.
- Outstanding counter:
  - +1 on transfer; −1 on done_irq; unchanged when both occur.
  - A done_irq while outstanding = 0 is ignored; the counter does not underflow.

## Timing
- Reset values:
  - state IDLE.
  - job_ready = 1.
  - cmd_valid = 0, cmd_data = 0.
  - busy = 0, job_done = 0, job_err = 0.
  - outstanding = 0.
- Accept edge (IDLE→ISSUE): the first command is valid on the next cycle. cmd_data is registered.
- Handshake rules:
  - While cmd_valid = 1 and cmd_ready = 0, cmd_data holds stable.
  - cmd_valid does not drop without a transfer, except on rst.
- Back-to-back transfers:
  - The next tile is presented in the cycle after a transfer. One command per cycle is allowed when no stall applies.
  - The outstanding value used by the issue check is the registered value, so the stall takes effect the cycle after outstanding reaches the limit.
- job_done is asserted the cycle after outstanding reaches 0 in DRAIN.
- A reset mid-job clears all state on that edge. Tiles already inside control_unit are not tracked afterward.
- Address wrap past 2^ADDR_WIDTH is silent.

## Test plan
- Single tile: M=K=N=16, bases a=0x000, b=0x100, c=0x200, d=0x300.
  - Expect exactly one cmd: len 16/16/16, addresses 0x000/0x100/0x200/0x300.
  - After one done_irq, job_done pulses once, one cycle later.
- Edge tiles: M=40, K=20, N=33 (MT=3, KT=2, NT=3), same bases.
  - Expect 18 cmds.
  - Tile (2,2,1): len_m=8, len_k=4, len_n=1; addr_a=0x050, addr_b=0x150, addr_c=addr_d=0x380.
- Hazard: K=32, M=N=16, done_irq held off for 10 cycles.
  - The second cmd (ki=1) is not presented until the cycle after outstanding returns to 0.
  - Its addr_c equals addr_d = 0x300.
- Backpressure and limit: K=16, M=N=96, cmd_ready toggled randomly, done_irq withheld.
  - cmd_data is stable whenever cmd_valid is high and cmd_ready is low.
  - Issue stops at outstanding=4; releasing one done_irq allows exactly one more transfer.
- Reject: job_n=0 → one-cycle job_err, no cmd_valid, job_ready stays 1.
- Reset mid-job plus spurious done_irq:
  - rst asserted after 3 transfers: the following cycle shows cmd_valid=0, outstanding=0, job_ready=1.
  - A done_irq while idle leaves outstanding at 0.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// Breaks one GEMM job (D = A*B + C) into a stream of SxS tile commands for control_unit.
// Walks tiles mi -> ni -> ki. Addresses come from running pointers. Issue is throttled by the in-flight tile count.
module gemm_tile_scheduler #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DIM_WIDTH            = 10,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   job_valid,
    output logic                                   job_ready,
    input  logic [DIM_WIDTH-1:0]                   job_m,
    input  logic [DIM_WIDTH-1:0]                   job_k,
    input  logic [DIM_WIDTH-1:0]                   job_n,
    input  logic [ADDR_WIDTH-1:0]                  job_base_a,
    input  logic [ADDR_WIDTH-1:0]                  job_base_b,
    input  logic [ADDR_WIDTH-1:0]                  job_base_c,
    input  logic [ADDR_WIDTH-1:0]                  job_base_d,
    output logic                                   cmd_valid,
    input  logic                                   cmd_ready,
    output logic [63:0]                            cmd_data,
    input  logic                                   done_irq,
    output logic                                   busy,
    output logic                                   job_done,
    output logic                                   job_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int                    OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DIM_WIDTH-1:0]  W_DIM     = DIM_WIDTH'(SYSTOLIC_ARRAY_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] W_ADDR    = ADDR_WIDTH'(SYSTOLIC_ARRAY_WIDTH);
    localparam logic [OUT_WIDTH-1:0]  MAX_OUT   = OUT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OUT_WIDTH-1:0]  ONE       = OUT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STALL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    // Current tile: elements remaining from the tile origin along each dimension, plus the address pointers.
    logic [DIM_WIDTH-1:0]  rem_m, rem_k, rem_n;
    logic [DIM_WIDTH-1:0]  lat_k, lat_n;
    logic [ADDR_WIDTH-1:0] lat_base_b;
    logic [ADDR_WIDTH-1:0] ptr_a, row_a, ptr_b, ptr_c, ptr_d;
    logic                  ki_nz;

    logic [DIM_WIDTH-1:0]  nxt_rem_m, nxt_rem_k, nxt_rem_n;
    logic [ADDR_WIDTH-1:0] nxt_a, nxt_row_a, nxt_b, nxt_c, nxt_d;
    logic                  nxt_ki_nz;
    logic                  last_m, last_k, last_n, last_tile;
    logic                  xfer, done_eff;
    logic [OUT_WIDTH-1:0]  outstanding_nxt;
    logic                  can_issue_now, can_issue_nxt;

    function automatic logic [7:0] len_of(input logic [DIM_WIDTH-1:0] rem);
        if (rem >= W_DIM)
            return 8'(SYSTOLIC_ARRAY_WIDTH);
        return 8'(rem);
    endfunction

    function automatic logic [63:0] pack_cmd(
        input logic [DIM_WIDTH-1:0]  rm, rk, rn,
        input logic [ADDR_WIDTH-1:0] a, b, c, d
    );
        logic [63:0] p;
        p                                 = '0;
        p[7:0]                            = len_of(rm);
        p[15:8]                           = len_of(rk);
        p[23:16]                          = len_of(rn);
        p[24 +: ADDR_WIDTH]               = a;
        p[24 + ADDR_WIDTH +: ADDR_WIDTH]  = b;
        p[24 + 2*ADDR_WIDTH +: ADDR_WIDTH] = c;
        p[24 + 3*ADDR_WIDTH +: ADDR_WIDTH] = d;
        return p;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        last_m    = (rem_m <= W_DIM);
        last_k    = (rem_k <= W_DIM);
        last_n    = (rem_n <= W_DIM);
        last_tile = last_m && last_k && last_n;
        xfer      = cmd_valid && cmd_ready;
        done_eff  = done_irq && (outstanding != '0);

        outstanding_nxt = outstanding;
        if (xfer && !done_eff)
            outstanding_nxt = outstanding + ONE;
        else if (!xfer && done_eff)
            outstanding_nxt = outstanding - ONE;

        nxt_rem_m = rem_m;
        nxt_rem_k = rem_k;
        nxt_rem_n = rem_n;
        nxt_a     = ptr_a;
        nxt_row_a = row_a;
        nxt_b     = ptr_b;
        nxt_c     = ptr_c;
        nxt_d     = ptr_d;
        nxt_ki_nz = ki_nz;
        if (!last_k) begin
            nxt_rem_k = rem_k - W_DIM;
            nxt_a     = ptr_a + W_ADDR;
            nxt_b     = ptr_b + W_ADDR;
            nxt_ki_nz = 1'b1;
        end else begin
            nxt_rem_k = lat_k;
            nxt_ki_nz = 1'b0;
            nxt_c     = ptr_c + W_ADDR;
            nxt_d     = ptr_d + W_ADDR;
            if (!last_n) begin
                // New output column in the same row band: A rewinds to the start of its row.
                nxt_rem_n = rem_n - W_DIM;
                nxt_a     = row_a;
                nxt_b     = ptr_b + W_ADDR;
            end else begin
                nxt_rem_n = lat_n;
                nxt_rem_m = rem_m - W_DIM;
                nxt_a     = ptr_a + W_ADDR;
                nxt_row_a = ptr_a + W_ADDR;
                nxt_b     = lat_base_b;
            end
        end

        // A ki > 0 tile reads the D partial sum, so it waits until no tile is in flight.
        can_issue_now = (outstanding < MAX_OUT) && (!ki_nz || outstanding == '0);
        can_issue_nxt = (outstanding_nxt < MAX_OUT) && (!nxt_ki_nz || outstanding_nxt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            job_ready   <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_data    <= '0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
            outstanding <= '0;
            rem_m       <= '0;
            rem_k       <= '0;
            rem_n       <= '0;
            lat_k       <= '0;
            lat_n       <= '0;
            lat_base_b  <= '0;
            ptr_a       <= '0;
            row_a       <= '0;
            ptr_b       <= '0;
            ptr_c       <= '0;
            ptr_d       <= '0;
            ki_nz       <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        if (job_m == '0 || job_k == '0 || job_n == '0) begin
                            job_err <= 1'b1;
                        end else begin
                            rem_m      <= job_m;
                            rem_k      <= job_k;
                            rem_n      <= job_n;
                            lat_k      <= job_k;
                            lat_n      <= job_n;
                            lat_base_b <= job_base_b;
                            ptr_a      <= job_base_a;
                            row_a      <= job_base_a;
                            ptr_b      <= job_base_b;
                            ptr_c      <= job_base_c;
                            ptr_d      <= job_base_d;
                            ki_nz      <= 1'b0;
                            cmd_data   <= pack_cmd(job_m, job_k, job_n, job_base_a,
                                                   job_base_b, job_base_c, job_base_d);
                            cmd_valid  <= 1'b1;
                            busy       <= 1'b1;
                            job_ready  <= 1'b0;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        if (last_tile) begin
                            cmd_valid <= 1'b0;
                            state     <= S_DRAIN;
                        end else begin
                            rem_m     <= nxt_rem_m;
                            rem_k     <= nxt_rem_k;
                            rem_n     <= nxt_rem_n;
                            ptr_a     <= nxt_a;
                            row_a     <= nxt_row_a;
                            ptr_b     <= nxt_b;
                            ptr_c     <= nxt_c;
                            ptr_d     <= nxt_d;
                            ki_nz     <= nxt_ki_nz;
                            cmd_data  <= pack_cmd(nxt_rem_m, nxt_rem_k, nxt_rem_n, nxt_a, nxt_b,
                                                  nxt_ki_nz ? nxt_d : nxt_c, nxt_d);
                            cmd_valid <= can_issue_nxt;
                            state     <= can_issue_nxt ? S_ISSUE : S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (can_issue_now) begin
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) begin
                        job_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: single tile, edge tiles, RAW hazard, backpressure/limit,
// reject, and reset mid-job. Outputs are sampled on the falling edge.
module tb_gemm_tile_scheduler;

    localparam int AW = 10;
    localparam int DW = 10;
    localparam int MO = 4;
    localparam int OW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [DW-1:0] job_m = '0, job_k = '0, job_n = '0;
    logic [AW-1:0] base_a = '0, base_b = '0, base_c = '0, base_d = '0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [63:0]   cmd_data;
    logic          done_irq;
    logic          man_done = 1'b0;
    logic          auto_done = 1'b0;
    logic          auto_pulse = 1'b0;
    logic          busy, job_done, job_err;
    logic [OW-1:0] outstanding;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int pend = 0;
    logic [63:0] xlog [0:255];

    int          xs, ds, es, early, viol, peak;
    logic        prev_valid, prev_ready;
    logic [63:0] held;

    always #5 clk = ~clk;

    assign done_irq = auto_done ? auto_pulse : man_done;

    gemm_tile_scheduler #(
        .ADDR_WIDTH(AW), .SYSTOLIC_ARRAY_WIDTH(16), .DIM_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_m(job_m), .job_k(job_k), .job_n(job_n),
        .job_base_a(base_a), .job_base_b(base_b), .job_base_c(base_c), .job_base_d(base_d),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .done_irq(done_irq), .busy(busy), .job_done(job_done), .job_err(job_err),
        .outstanding(outstanding)
    );

    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            xlog[xfers % 256] <= cmd_data;
            xfers             <= xfers + 1;
        end
        if (job_done) done_pulses <= done_pulses + 1;
        if (job_err)  err_pulses  <= err_pulses + 1;
    end

    // Auto responder: returns one done_irq per cycle while tiles are pending.
    always @(posedge clk) begin
        if (rst)
            pend <= 0;
        else
            pend <= pend + ((cmd_valid && cmd_ready) ? 1 : 0) - ((done_irq && pend > 0) ? 1 : 0);
    end

    always @(negedge clk) auto_pulse <= auto_done && (pend > 0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cmd(input int lm, lk, ln, a, b, c, d);
        logic [63:0] v;
        v        = '0;
        v[7:0]   = 8'(lm);
        v[15:8]  = 8'(lk);
        v[23:16] = 8'(ln);
        v[33:24] = 10'(a);
        v[43:34] = 10'(b);
        v[53:44] = 10'(c);
        v[63:54] = 10'(d);
        return v;
    endfunction

    task automatic submit(input int m, k, n);
        job_m     = DW'(m);
        job_k     = DW'(k);
        job_n     = DW'(n);
        base_a    = 10'h000;
        base_b    = 10'h100;
        base_c    = 10'h200;
        base_d    = 10'h300;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_pulses;
        n     = 0;
        while (done_pulses == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done_pulses - start), 64'd1);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_job_ready", job_ready, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_job_done", job_done, 0);
        check("rst_job_err", job_err, 0);
        check("rst_outstanding", outstanding, 0);

        // Single 16x16x16 tile
        ds = done_pulses;
        submit(16, 16, 16);
        check("single_valid", cmd_valid, 1);
        check("single_data", cmd_data, exp_cmd(16, 16, 16, 'h000, 'h100, 'h200, 'h300));
        check("single_busy", busy, 1);
        check("single_job_ready", job_ready, 0);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("single_out1", outstanding, 1);
        check("single_valid_after", cmd_valid, 0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("single_out0", outstanding, 0);
        check("single_done_early", job_done, 0);
        @(negedge clk);
        check("single_done", job_done, 1);
        @(negedge clk);
        check("single_done_drop", job_done, 0);
        check("single_idle_ready", job_ready, 1);
        check("single_idle_busy", busy, 0);
        check("single_done_cnt", 64'(done_pulses - ds), 1);

        // Edge tiles: M=40 K=20 N=33 -> 3x2x3 tiles
        xs        = xfers;
        cmd_ready = 1'b1;
        auto_done = 1'b1;
        submit(40, 20, 33);
        wait_done("edge_done", 400);
        auto_done = 1'b0;
        cmd_ready = 1'b0;
        check("edge_count", 64'(xfers - xs), 18);
        check("edge_t0", xlog[xs + 0], exp_cmd(16, 16, 16, 'h000, 'h100, 'h200, 'h300));
        check("edge_t001", xlog[xs + 1], exp_cmd(16, 4, 16, 'h010, 'h110, 'h300, 'h300));
        check("edge_t020", xlog[xs + 4], exp_cmd(16, 16, 1, 'h000, 'h140, 'h220, 'h320));
        check("edge_t100", xlog[xs + 6], exp_cmd(16, 16, 16, 'h020, 'h100, 'h230, 'h330));
        check("edge_t221", xlog[xs + 17], exp_cmd(8, 4, 1, 'h050, 'h150, 'h380, 'h380));

        // RAW hazard: K=32, second tile waits for outstanding to return to 0
        cmd_ready = 1'b1;
        submit(16, 32, 16);
        check("haz_t0", cmd_data, exp_cmd(16, 16, 16, 'h000, 'h100, 'h200, 'h300));
        early = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_valid) early++;
        end
        check("haz_held_off", 64'(early), 0);
        check("haz_out1", outstanding, 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("haz_out0", outstanding, 0);
        check("haz_not_yet", cmd_valid, 0);
        @(negedge clk);
        check("haz_present", cmd_valid, 1);
        check("haz_t1", cmd_data, exp_cmd(16, 16, 16, 'h010, 'h110, 'h300, 'h300));
        @(negedge clk);
        cmd_ready = 1'b0;
        check("haz_out_after", outstanding, 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_done("haz_done", 10);

        // Backpressure and outstanding limit: M=N=96, K=16, no done_irq
        xs         = xfers;
        viol       = 0;
        peak       = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        held       = '0;
        submit(96, 16, 96);
        for (int i = 0; i < 60; i++) begin
            if (prev_valid && !prev_ready && (!cmd_valid || cmd_data !== held)) viol++;
            cmd_ready  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            prev_valid = cmd_valid;
            prev_ready = cmd_ready;
            held       = cmd_data;
            if (int'(outstanding) > peak) peak = int'(outstanding);
            @(negedge clk);
        end
        check("bp_stable", 64'(viol), 0);
        check("bp_xfers", 64'(xfers - xs), 4);
        check("bp_out", outstanding, 4);
        check("bp_peak", 64'(peak), 4);
        check("bp_stalled", cmd_valid, 0);
        cmd_ready = 1'b1;
        man_done  = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (10) @(negedge clk);
        check("bp_one_more", 64'(xfers - xs), 5);
        check("bp_out_again", outstanding, 4);
        rst       = 1'b1;
        cmd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reject: job_n = 0
        es = err_pulses;
        submit(16, 16, 0);
        check("rej_err", job_err, 1);
        check("rej_valid", cmd_valid, 0);
        check("rej_ready", job_ready, 1);
        @(negedge clk);
        check("rej_err_drop", job_err, 0);
        check("rej_ready2", job_ready, 1);
        check("rej_valid2", cmd_valid, 0);
        check("rej_err_cnt", 64'(err_pulses - es), 1);

        // Reset mid-job after 3 transfers, then spurious done_irq while idle
        xs        = xfers;
        cmd_ready = 1'b1;
        submit(96, 16, 96);
        for (int i = 0; i < 20 && (xfers - xs) < 3; i++) @(negedge clk);
        check("rstmid_xfers", 64'(xfers - xs), 3);
        rst       = 1'b1;
        cmd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_valid", cmd_valid, 0);
        check("rstmid_out", outstanding, 0);
        check("rstmid_ready", job_ready, 1);
        check("rstmid_busy", busy, 0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("spurious_done_out", outstanding, 0);
        @(negedge clk);
        check("spurious_done_out2", outstanding, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
